mc_fetch: RTL and testbench
===========================

# mc_fetch

Instruction fetch unit for the multicycle MIPS core, directly upstream of the multicycle control FSM. When the controller is in its fetch state it requests an instruction; this block issues a valid/ready memory request, waits for the response, and loads the instruction register. It then presents `op`/`func` and the instruction's PC to the FSM and datapath. It also holds the next-PC register, which is updated by sequential increment or by branch/jump redirects from the execute stage.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetch address after reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_start`  in  1  controller is in its fetch state and requests the next instruction; sampled only in IDLE.
- `ireq_valid`  out  1  instruction memory request valid.
- `ireq_addr`  out  32  request byte address; `[1:0]` is always `00`.
- `ireq_ready`  in  1  memory accepts the request.
- `iresp_valid`  in  1  response data valid.
- `iresp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch taken or jump, from the execute stage.
- `redirect_pc`  in  32  redirect target.
- `ir`  out  32  instruction register.
- `op`  out  6  `ir[31:26]`.
- `func`  out  6  `ir[5:0]`.
- `pc`  out  32  address of the instruction held in `ir`.
- `pc_plus4`  out  32  `pc + 4`, for branch offset calculation.
- `fetch_done`  out  1  one-cycle pulse: `ir`/`pc` were updated on this cycle's opening edge.
- `busy`  out  1  high in REQ or WAIT.
- `fetch_err`  out  1  sticky misalignment flag; see Configuration.

## Operation
- Internal registers:
  - `next_pc`: address of the next fetch.
  - `fetch_addr`: address of the in-flight fetch.
  - `state`: one of IDLE, REQ, WAIT.
- Reset values:
  - `state`=IDLE, `next_pc`=`RESET_PC`, `fetch_addr`=`RESET_PC`.
  - `ir`=0 (NOP, so `op`=0 and `func`=0), `pc`=0.
  - `ireq_valid`=0, `fetch_done`=0, `busy`=0, `fetch_err`=0.
- IDLE:
  - `fetch_start`=1 → `fetch_addr`←`next_pc`, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `ireq_valid`=1 and `ireq_addr`=`fetch_addr`, both held stable until `ireq_ready`=1.
  - On the handshake, go to WAIT.
  - `iresp_valid` is ignored in REQ.
- WAIT:
  - On `iresp_valid`=1: `ir`←`iresp_data`, `pc`←`fetch_addr`, `next_pc`←`fetch_addr`+4 (modulo 2^32), `fetch_done`←1, go to IDLE.
- `fetch_done` is registered and deasserts on the following cycle.
- Redirect:
  - `redirect_valid`=1 in any state → `next_pc`←`redirect_pc`.
  - If it coincides with response completion, the redirect wins over the +4 increment.
  - An in-flight `fetch_addr` is never altered.
- `fetch_start` in REQ or WAIT is ignored; it is not queued.
- `iresp_valid` in IDLE is ignored. Stray responses are dropped.
- Reset mid-operation: all registers return to reset values immediately. A response arriving after reset release while in IDLE is dropped.
- `pc_plus4` is combinational from `pc`. `op` and `func` are combinational slices of `ir`.

## Timing
- `fetch_start` at cycle t → `ireq_valid` high from t+1.
- Handshake at cycle a → WAIT from a+1. The earliest response is in cycle a+1.
- Response at cycle r → `ir`, `pc` and `fetch_done` are visible in cycle r+1.
- Zero-wait memory latency, `fetch_start` to `fetch_done`: 3 cycles.
- Back-to-back issue: `fetch_start` can be accepted in the same cycle `fetch_done` is high. One fetch is in flight at a time.

## Configuration
- `MC_FETCH_ALIGN_CHK_EN` defined:
  - At `fetch_start` in IDLE, if `next_pc[1:0]`≠0, no request is issued.
  - Instead: `ir`←0, `pc`←`next_pc`, `fetch_err`←1, `fetch_done` pulses at t+1, state stays IDLE, `next_pc` is unchanged.
  - `fetch_err` stays set until reset.
- `MC_FETCH_ALIGN_CHK_EN` undefined:
  - `fetch_err` is tied to 0.
  - `ireq_addr`, `pc` and `next_pc` force bits `[1:0]` to `00`; `redirect_pc[1:0]` is discarded.

## Test plan
- Reset, then `fetch_start` → `ireq_addr`=`32'hBFC0_0000`; before any fetch, `ir`=0, `op`=0, `func`=0.
- Zero-wait: `ireq_ready`=1, response `32'h8C08_0004` one cycle after the handshake → `fetch_done` at t+3, `op`=`6'h23`, `pc`=`BFC0_0000`, `pc_plus4`=`BFC0_0004`; next `ireq_addr`=`BFC0_0004`.
- Backpressure: `ireq_ready` low for 3 cycles → `ireq_valid` stays 1 with `ireq_addr` constant; WAIT entered only on the cycle after `ready` goes high. `fetch_start` pulsed during REQ has no effect.
- Redirect to `32'h8000_0100` in the same cycle as `iresp_valid` → `pc`=old `fetch_addr`; the next request address is `8000_0100`, not old+4.
- Reset asserted in WAIT, then `iresp_valid` after release → the response is dropped, `ir`=0, and the next fetch uses `BFC0_0000`.
- Macro on: redirect to `32'h8000_0102`, then `fetch_start` → `ireq_valid` never asserted, `fetch_done` at t+1, `fetch_err`=1, `ir`=0. Macro off: the same stimulus yields `ireq_addr`=`8000_0100`.

Source files
------------

// File: rtl/mc_fetch.sv
// ============================================================================
// Module   : mc_fetch
// Brief    : Multicycle MIPS instruction fetch unit with valid/ready memory
//            request, instruction register and next-PC/redirect handling.
//            Optional build macro MC_FETCH_ALIGN_CHK_EN enables misalignment
//            detection; otherwise addresses are forced word-aligned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_done,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_REQ        = 2'd1;
    localparam logic [1:0]  c_WAIT       = 2'd2;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_next_pc;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_fetch_done;
    logic        w_issue;
    logic        w_load;
    logic        w_misfetch;
    logic        w_misaligned;
    logic [31:0] w_redirect_pc;

`ifdef MC_FETCH_ALIGN_CHK_EN
    logic        r_fetch_err;

    assign w_misaligned  = (r_next_pc[1:0] != 2'b00);
    assign w_redirect_pc = redirect_pc;
    assign fetch_err     = r_fetch_err;
`else
    assign w_misaligned  = 1'b0;
    assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;
    assign fetch_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A misaligned start completes in IDLE without ever issuing a request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (fetch_start && !w_misaligned) w_state_nxt = c_REQ;
            c_REQ:  if (ireq_ready)                   w_state_nxt = c_WAIT;
            c_WAIT: if (iresp_valid)                  w_state_nxt = c_IDLE;
            default:                                  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        ireq_valid = (r_state == c_REQ);
        busy       = (r_state == c_REQ) || (r_state == c_WAIT);
        w_issue    = (r_state == c_IDLE) && fetch_start && !w_misaligned;
        w_misfetch = (r_state == c_IDLE) && fetch_start && w_misaligned;
        w_load     = (r_state == c_WAIT) && iresp_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_pc    <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_ir         <= 32'h0;
            r_pc         <= 32'h0;
            r_fetch_done <= 1'b0;
        end else begin
            r_fetch_done <= w_load || w_misfetch;
            if (w_issue) begin
                r_fetch_addr <= r_next_pc;
            end
            if (w_load) begin
                r_ir <= iresp_data;
                r_pc <= r_fetch_addr;
            end else if (w_misfetch) begin
                r_ir <= 32'h0;
                r_pc <= r_next_pc;
            end
            // Redirect takes priority over the sequential increment.
            if (redirect_valid) begin
                r_next_pc <= w_redirect_pc;
            end else if (w_load) begin
                r_next_pc <= r_fetch_addr + 32'd4;
            end
        end
    end

`ifdef MC_FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_err <= 1'b0;
        end else if (w_misfetch) begin
            r_fetch_err <= 1'b1;
        end
    end
`endif

    assign ireq_addr  = r_fetch_addr & c_ALIGN_MASK;
    assign ir         = r_ir;
    assign op         = r_ir[31:26];
    assign func       = r_ir[5:0];
    assign pc         = r_pc;
    assign pc_plus4   = r_pc + 32'd4;
    assign fetch_done = r_fetch_done;

endmodule

`default_nettype wire

// File: tb/tb_mc_fetch.sv
// ============================================================================
// Module   : tb_mc_fetch
// Brief    : Directed and randomized self-checking bench for mc_fetch against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ir;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    mc_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_start    (fetch_start),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_ready     (ireq_ready),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir             (ir),
        .op             (op),
        .func           (func),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .fetch_done     (fetch_done),
        .busy           (busy),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction, tracked as booleans.
    bit          m_inflight;
    bit          m_accepted;
    logic [31:0] m_next;
    logic [31:0] m_addr;
    logic [31:0] m_ir;
    logic [31:0] m_pc;
    bit          m_done;
    bit          m_err;

    task automatic model_reset();
        m_inflight = 0;
        m_accepted = 0;
        m_next     = 32'hBFC0_0000;
        m_addr     = 32'hBFC0_0000;
        m_ir       = 0;
        m_pc       = 0;
        m_done     = 0;
        m_err      = 0;
    endtask

    task automatic model_tick();
        logic [31:0] nxt;
        bit          bad_align;
        if (!reset) begin
            model_reset();
            return;
        end
        nxt    = m_next;
        m_done = 0;
`ifdef MC_FETCH_ALIGN_CHK_EN
        bad_align = (m_next % 4) != 0;
`else
        bad_align = 0;
`endif
        if (!m_inflight) begin
            if (fetch_start) begin
                if (bad_align) begin
                    m_ir   = 0;
                    m_pc   = m_next;
                    m_err  = 1;
                    m_done = 1;
                end else begin
                    m_addr     = m_next;
                    m_inflight = 1;
                    m_accepted = 0;
                end
            end
        end else if (!m_accepted) begin
            if (ireq_ready) m_accepted = 1;
        end else if (iresp_valid) begin
            m_ir       = iresp_data;
            m_pc       = m_addr;
            nxt        = m_addr + 4;
            m_done     = 1;
            m_inflight = 0;
        end
        if (redirect_valid) begin
`ifdef MC_FETCH_ALIGN_CHK_EN
            nxt = redirect_pc;
`else
            nxt = (redirect_pc / 4) * 4;
`endif
        end
        m_next = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_ir;
        e_ir = m_ir;
        chk("ireq_valid", {31'b0, ireq_valid}, {31'b0, m_inflight && !m_accepted});
        if (m_inflight && !m_accepted) chk("ireq_addr", ireq_addr, m_addr);
        chk("ir", ir, m_ir);
        chk("op", {26'b0, op}, {26'b0, e_ir[31:26]});
        chk("func", {26'b0, func}, {26'b0, e_ir[5:0]});
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fetch_done", {31'b0, fetch_done}, {31'b0, m_done});
        chk("busy", {31'b0, busy}, {31'b0, m_inflight});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset          = 1'b0;
        fetch_start    = 1'b0;
        ireq_ready     = 1'b0;
        iresp_valid    = 1'b0;
        iresp_data     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_ir", ir, 32'h0);
        chk("rst_op", {26'b0, op}, 32'h0);
        chk("rst_func", {26'b0, func}, 32'h0);
        reset = 1'b1;
        step();

        // Zero-wait fetch: fetch_done three cycles after fetch_start.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("zw_valid", {31'b0, ireq_valid}, 32'h1);
        chk("zw_addr", ireq_addr, 32'hBFC0_0000);
        ireq_ready = 1'b1;
        step();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        iresp_data  = 32'h8C08_0004;
        step();
        iresp_valid = 1'b0;
        chk("zw_done", {31'b0, fetch_done}, 32'h1);
        chk("zw_op", {26'b0, op}, 32'h23);
        chk("zw_func", {26'b0, func}, 32'h04);
        chk("zw_pc", pc, 32'hBFC0_0000);
        chk("zw_pc4", pc_plus4, 32'hBFC0_0004);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("b2b_addr", ireq_addr, 32'hBFC0_0004);

        // Backpressure with a stray fetch_start while in REQ.
        for (int i = 0; i < 3; i++) begin
            fetch_start = (i == 1);
            step();
            chk("bp_valid", {31'b0, ireq_valid}, 32'h1);
            chk("bp_addr", ireq_addr, 32'hBFC0_0004);
        end
        fetch_start = 1'b0;
        ireq_ready  = 1'b1;
        step();
        ireq_ready = 1'b0;
        chk("bp_wait", {31'b0, ireq_valid}, 32'h0);

        // Redirect coinciding with the response.
        iresp_valid    = 1'b1;
        iresp_data     = $urandom;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        iresp_valid    = 1'b0;
        redirect_valid = 1'b0;
        chk("rd_pc", pc, 32'hBFC0_0004);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("rd_addr", ireq_addr, 32'h8000_0100);

        // Reset while waiting; late response after release is dropped.
        ireq_ready = 1'b1;
        step();
        ireq_ready = 1'b0;
        reset = 1'b0;
        step();
        chk("rw_busy", {31'b0, busy}, 32'h0);
        reset       = 1'b1;
        iresp_valid = 1'b1;
        iresp_data  = 32'hDEAD_BEEF;
        step();
        iresp_valid = 1'b0;
        chk("rw_ir", ir, 32'h0);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("rw_addr", ireq_addr, 32'hBFC0_0000);
        ireq_ready = 1'b1;
        step();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        step();
        iresp_valid = 1'b0;

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        fetch_start    = 1'b1;
        step();
        fetch_start = 1'b0;
`ifdef MC_FETCH_ALIGN_CHK_EN
        chk("ma_valid", {31'b0, ireq_valid}, 32'h0);
        chk("ma_done", {31'b0, fetch_done}, 32'h1);
        chk("ma_err", {31'b0, fetch_err}, 32'h1);
        chk("ma_ir", ir, 32'h0);
        chk("ma_pc", pc, 32'h8000_0102);
        step();
        chk("ma_valid2", {31'b0, ireq_valid}, 32'h0);
`else
        chk("ma_valid", {31'b0, ireq_valid}, 32'h1);
        chk("ma_addr", ireq_addr, 32'h8000_0100);
        chk("ma_err", {31'b0, fetch_err}, 32'h0);
        ireq_ready = 1'b1;
        step();
        ireq_ready  = 1'b0;
        iresp_valid = 1'b1;
        step();
        iresp_valid = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) != 0);
            fetch_start    = ($urandom_range(0, 1) == 1);
            ireq_ready     = ($urandom_range(0, 1) == 1);
            iresp_valid    = ($urandom_range(0, 2) == 0);
            iresp_data     = $urandom;
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 9) != 0) redirect_pc[1:0] = 2'b00;
            step();
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
